// File: rtl/lzc_seq_if.sv
// Handshake bundle for lzc_seq: operand channel in, zero-count result channel out.
// Signal suffixes are from the counter's point of view (slave modport).
interface lzc_seq_if #(
  parameter int unsigned WIDTH = 64
);
  localparam int unsigned CNT_WIDTH = $clog2(WIDTH + 1);

  logic                 valid_i;
  logic                 ready_o;
  logic [WIDTH-1:0]     data_i;
  logic                 mode_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [CNT_WIDTH-1:0] cnt_o;
  logic                 empty_o;
  logic                 busy_o;

  modport master (
    output valid_i, data_i, mode_i, ready_i,
    input  ready_o, valid_o, cnt_o, empty_o, busy_o
  );

  modport slave (
    input  valid_i, data_i, mode_i, ready_i,
    output ready_o, valid_o, cnt_o, empty_o, busy_o
  );
endinterface

// File: rtl/lzc_seq.sv
// Iterative leading/trailing zero counter, one CHUNK-bit slice per cycle.
// Optional LZC_SEQ_EARLY_EXIT_EN: leave SCAN on the first nonzero slice (data-dependent latency).
module lzc_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input logic          clk_i,
  input logic          rst_ni,
  lzc_seq_if.slave     io
);
  localparam int unsigned NUM_CHUNKS = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned CNT_WIDTH  = $clog2(WIDTH + 1);
  localparam int unsigned IDX_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned PAD_WIDTH  = NUM_CHUNKS * CHUNK;
  localparam int unsigned LAST_BITS  = WIDTH - (NUM_CHUNKS - 1) * CHUNK;

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_cfg
    $fatal(1, "lzc_seq: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   acc_q, acc_d;
  logic                   found_q, found_d;

  logic [WIDTH-1:0]       data_rev;
  logic [PAD_WIDTH-1:0]   data_pad;
  logic [CHUNK-1:0]       slice;
  logic [CNT_WIDTH-1:0]   slice_tz;
  logic [CNT_WIDTH-1:0]   slice_bits;
  logic                   slice_nz;
  logic                   last_slice;
  logic                   ready;
  logic                   accept;

  // Leading-zero mode is a trailing-zero scan of the bit-reversed operand.
  always_comb begin
    data_rev = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      data_rev[i] = io.data_i[int'(WIDTH) - 1 - i];
    end
  end

  // Padding bits above WIDTH read as zero and are never counted.
  assign data_pad   = PAD_WIDTH'(data_q);
  assign slice      = data_pad[int'(idx_q) * int'(CHUNK) +: CHUNK];
  assign slice_nz   = |slice;
  assign last_slice = (idx_q == IDX_WIDTH'(NUM_CHUNKS - 1));
  assign slice_bits = last_slice ? CNT_WIDTH'(LAST_BITS) : CNT_WIDTH'(CHUNK);

  always_comb begin
    slice_tz = '0;
    for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
      if (slice[i]) slice_tz = CNT_WIDTH'(i);
    end
  end

  always_comb begin
    unique case (state_q)
      StIdle:  ready = 1'b1;
      StDone:  ready = io.ready_i;
      default: ready = 1'b0;
    endcase
  end

  assign accept = io.valid_i && ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    found_d = found_q;

    if (accept) begin
      data_d  = io.mode_i ? data_rev : io.data_i;
      idx_d   = '0;
      acc_d   = '0;
      found_d = 1'b0;
      state_d = StScan;
    end

    unique case (state_q)
      StIdle: ;
      StScan: begin
        // Accumulator stops moving once the first set bit has been counted.
        if (!found_q) begin
          if (slice_nz) begin
            acc_d   = acc_q + slice_tz;
            found_d = 1'b1;
          end else begin
            acc_d = acc_q + slice_bits;
          end
        end
`ifdef LZC_SEQ_EARLY_EXIT_EN
        if (last_slice || (!found_q && slice_nz)) begin
`else
        if (last_slice) begin
`endif
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (io.ready_i && !io.valid_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      data_q  <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      found_q <= found_d;
    end
  end

  assign io.ready_o = ready;
  assign io.valid_o = (state_q == StDone);
  assign io.busy_o  = (state_q == StScan);
  assign io.cnt_o   = acc_q;
  assign io.empty_o = (state_q == StDone) && !found_q;
endmodule

// File: tb/tb_lzc_seq.sv
// Directed bench for lzc_seq: a 64/16 instance and a 20/8 (partial last slice) instance.
module tb_lzc_seq;
`ifdef LZC_SEQ_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lzc_seq_if #(.WIDTH(64)) bus64 ();
  lzc_seq_if #(.WIDTH(20)) bus20 ();

  lzc_seq #(.WIDTH(64), .CHUNK(16)) u_dut64 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (bus64)
  );

  lzc_seq #(.WIDTH(20), .CHUNK(8)) u_dut20 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (bus20)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic m, input logic [63:0] d,
                       input logic r);
    if (sel) begin
      bus20.valid_i = v; bus20.mode_i = m; bus20.data_i = d[19:0]; bus20.ready_i = r;
    end else begin
      bus64.valid_i = v; bus64.mode_i = m; bus64.data_i = d;       bus64.ready_i = r;
    end
  endtask

  function automatic logic out_valid(input bit sel);
    return sel ? bus20.valid_o : bus64.valid_o;
  endfunction

  function automatic logic [63:0] out_cnt(input bit sel);
    return sel ? 64'(bus20.cnt_o) : 64'(bus64.cnt_o);
  endfunction

  function automatic logic out_empty(input bit sel);
    return sel ? bus20.empty_o : bus64.empty_o;
  endfunction

  // k = slice holding the first set bit in scan order, -1 for an all-zero operand.
  function automatic int exp_lat(input bit sel, input int k);
    int nch;
    nch = sel ? 3 : 4;
    if (k < 0 || !EarlyExit) return nch + 1;
    return k + 2;
  endfunction

  // Called just after the acceptance edge; returns the cycle index where valid_o is seen.
  task automatic wait_valid(input bit sel, output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid(sel) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input bit sel, input string tag, input logic m, input logic [63:0] d,
                     input int exp_c, input logic exp_e, input int k);
    int lat;
    @(negedge clk);
    drive(sel, 1'b1, m, d, 1'b1);
    @(posedge clk);
    #1 drive(sel, 1'b0, ~m, ~d, 1'b1);
    wait_valid(sel, lat);
    check({tag, "_cnt"}, out_cnt(sel), 64'(exp_c));
    check({tag, "_empty"}, 64'(out_empty(sel)), 64'(exp_e));
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat(sel, k)));
  endtask

  initial begin
    int lat;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(bus64.valid_o), 64'd0);
    check("rst_cnt",   64'(bus64.cnt_o),   64'd0);
    check("rst_empty", 64'(bus64.empty_o), 64'd0);
    check("rst_busy",  64'(bus64.busy_o),  64'd0);
    check("rst_ready", 64'(bus64.ready_o), 64'd1);
    rst_n = 1'b1;

    // Main function, 64-bit instance.
    run(1'b0, "tz_bit3",   1'b0, 64'h8,                    3,  1'b0, 0);
    run(1'b0, "lz_bit40",  1'b1, 64'h0000_0100_0000_0000, 23, 1'b0, 1);
    run(1'b0, "tz_zero",   1'b0, 64'h0,                   64, 1'b1, -1);
    run(1'b0, "lz_zero",   1'b1, 64'h0,                   64, 1'b1, -1);
    run(1'b0, "tz_bit63",  1'b0, 64'h8000_0000_0000_0000, 63, 1'b0, 3);
    run(1'b0, "lz_ones",   1'b1, 64'hFFFF_FFFF_FFFF_FFFF,  0, 1'b0, 0);
    run(1'b0, "tz_bit37",  1'b0, 64'h0000_0020_0000_0001,  0, 1'b0, 0);

    // Back-pressure then back-to-back acceptance.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 64'h4, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b1, 64'hFF, 1'b0);
    wait_valid(1'b0, lat);
    check("bp_first_cnt", out_cnt(1'b0), 64'd2);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(bus64.valid_o), 64'd1);
      check("bp_hold_cnt",   64'(bus64.cnt_o),   64'd2);
      check("bp_hold_empty", 64'(bus64.empty_o), 64'd0);
      check("bp_hold_ready", 64'(bus64.ready_o), 64'd0);
    end
    drive(1'b0, 1'b1, 1'b0, 64'h1, 1'b1);
    #1 check("b2b_ready", 64'(bus64.ready_o), 64'd1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    check("b2b_busy", 64'(bus64.busy_o), 64'd1);
    wait_valid(1'b0, lat);
    check("b2b_cnt", out_cnt(1'b0), 64'd0);
    check("b2b_lat", 64'(lat), 64'(exp_lat(1'b0, 0)));

    // Reset in the middle of a scan.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
    @(negedge clk);
    check("mid_busy", 64'(bus64.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus64.valid_o), 64'd0);
    check("abort_busy",  64'(bus64.busy_o),  64'd0);
    check("abort_ready", 64'(bus64.ready_o), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, "after_rst", 1'b0, 64'h10, 4, 1'b0, 0);

    // Partial last slice, 20-bit instance.
    run(1'b1, "w20_zero",  1'b0, 64'h0,      20, 1'b1, -1);
    run(1'b1, "w20_lz19",  1'b1, 64'h80000,   0, 1'b0, 0);
    run(1'b1, "w20_tz16",  1'b0, 64'h10000,  16, 1'b0, 2);
    run(1'b1, "w20_lz0",   1'b1, 64'h1,      19, 1'b0, 2);
    run(1'b1, "w20_lzzero", 1'b1, 64'h0,     20, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
